// File: rtl/ram_stream_reader_pkg.sv
// Shared encodings for the RAM read sequencer: FSM states and output buffer depth.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Valid/ready word stream leaving the reader toward downstream consumers.
interface ram_stream_reader_if #(
  parameter int SIZE = 8
);
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ram_stream_reader_stream_fifo2.sv
// Two-entry synchronous FIFO; the head entry is presented directly as the stream word.
module stream_fifo2
  import ram_stream_reader_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [SIZE-1:0] push_data,
  input  logic            pop,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  output logic [1:0]      count,
  output logic            full,
  output logic            empty
);

  logic [SIZE-1:0] mem_reg [BUF_DEPTH];
  logic            wr_ptr_reg;
  logic            rd_ptr_reg;
  logic [1:0]      count_reg;
  logic [1:0]      count_next;
  logic            do_push;
  logic            do_pop;

  assign empty     = (count_reg == 2'd0);
  assign full      = (count_reg == 2'(BUF_DEPTH));
  assign count     = count_reg;
  assign out_valid = !empty;
  assign out_data  = mem_reg[rd_ptr_reg];

  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a wrap-around window of a simple dual-port RAM read port and streams the
// words out with full backpressure, hiding the RAM's one-cycle read latency.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter  int SIZE  = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW-1:0]     start_addr,
  input  logic [AW:0]       count,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     raddr,
  input  logic [SIZE-1:0]   read_data,
  ram_stream_reader_if.master strm
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   REM_LAST  = {{AW{1'b0}}, 1'b1};

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [AW:0]     remaining_reg, remaining_next;
  logic            rd_pend_reg;
  logic            done_reg, done_next;
  logic            issue;
  logic            pop;
  logic [1:0]      buf_count;
  logic [2:0]      occ;
  logic            fifo_full;
  logic            fifo_empty;
  logic            unused_flags;

  assign busy  = (state_reg != IDLE);
  assign done  = done_reg;
  assign raddr = addr_reg;
  assign pop   = strm.out_valid && strm.out_ready;

  // Occupancy the buffer will hold after this edge if nothing new is issued.
  assign occ   = {1'b0, buf_count} + {2'b00, rd_pend_reg} - {2'b00, pop};
  assign issue = (state_reg == READ) && (occ < 3'(BUF_DEPTH));

  assign unused_flags = fifo_full ^ fifo_empty;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_next     = READ;
            addr_next      = start_addr;
            remaining_next = count;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_next      = (addr_reg == ADDR_LAST) ? '0 : addr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == REM_LAST) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Nothing in flight and one word left: this handshake finishes the job.
        if (!rd_pend_reg && (buf_count == 2'd1) && pop) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      rd_pend_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      rd_pend_reg   <= issue;
      done_reg      <= done_next;
    end
  end

  stream_fifo2 #(
    .SIZE (SIZE)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend_reg),
    .push_data (read_data),
    .pop       (pop),
    .out_data  (strm.out_data),
    .out_valid (strm.out_valid),
    .count     (buf_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
